// File: rtl/ra_builder.sv
// ra_builder
// Writes a PVR Region Array into VRAM for a (tiles_x+1) x (tiles_y+1) tile grid.
// Each entry is a control word followed by one Object List pointer per list
// type (O, OM, T, TM and, in the v2 format, PT). The pointers are laid out
// from OL_BASE using the per-type OPB sizes, matching the region-array parser.
//
// Optional feature macro: RA_BUILDER_FMT_V2_EN
//   defined   : FPU_PARAM_CFG[21] selects v1 (five words) or v2 (six words, adds PT)
//   undefined : always v1; the PT size still feeds the base chain but is never written
`timescale 1ns/1ps
module ra_builder (
    input  logic        clock,
    input  logic        reset,
    input  logic        ra_build_trig,
    input  logic [31:0] FPU_PARAM_CFG,
    input  logic [31:0] TA_ALLOC_CTRL,
    input  logic [23:0] REGION_BASE,
    input  logic [23:0] OL_BASE,
    input  logic [5:0]  tiles_x,
    input  logic [5:0]  tiles_y,
    input  logic        zclear_dis,
    output logic        ra_vram_wr,
    output logic [23:0] ra_vram_addr,
    output logic [31:0] ra_vram_dout,
    input  logic        ra_vram_wait,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_WR_CTRL = 3'd2;
    localparam logic [2:0] S_WR_PTR  = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state;
    logic [5:0]        last_x;
    logic [5:0]        last_y;
    logic [5:0]        cur_x;
    logic [5:0]        cur_y;
    logic              zclear_q;
    logic [4:0][1:0]   opb_q;
    logic [23:0]       ol_base_q;
    logic [4:0][23:0]  base_q;
    logic [2:0]        step_k;
    logic [11:0]       tile_idx;
    logic [23:0]       addr_q;

    logic [12:0]       num_tiles;
    logic [23:0]       setup_base;
    logic              is_last;
    logic [31:0]       ctrl_word;
    logic [31:0]       ptr_word;
    logic [2:0]        last_ptr_k;
    logic              write_ok;

    // Byte span of 'count' lists of one type: zero when the type is disabled,
    // otherwise count * (16 << opb), done as a shift since sizes are powers of two.
    function automatic logic [23:0] scaled(input logic [12:0] count, input logic [1:0] opb);
        logic [23:0] wide;
        wide = {11'd0, count} << (3'd4 + {1'b0, opb});
        if (opb == 2'd0) begin
            wide = 24'd0;
        end
        return wide;
    endfunction

    assign num_tiles = ({7'd0, last_x} + 13'd1) * ({7'd0, last_y} + 13'd1);
    assign is_last   = (cur_x == last_x) && (cur_y == last_y);
    assign ctrl_word = {is_last, zclear_q, 2'b00, 14'd0, cur_y, cur_x, 2'b00};
    assign ptr_word  = (opb_q[step_k] == 2'd0) ? 32'h8000_0000
                     : {8'h00, base_q[step_k] + scaled({1'b0, tile_idx}, opb_q[step_k])};
    assign write_ok  = !ra_vram_wait;

`ifdef RA_BUILDER_FMT_V2_EN
    logic fmt_v2;
    logic unused_cfg;

    // Entry format is frozen at trigger time like every other input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fmt_v2 <= 1'b0;
        end else if (state == S_IDLE && ra_build_trig) begin
            fmt_v2 <= FPU_PARAM_CFG[21];
        end
    end

    assign last_ptr_k = fmt_v2 ? 3'd4 : 3'd3;
    assign unused_cfg = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                          TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14],
                          TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6], TA_ALLOC_CTRL[3:2]};
`else
    logic unused_cfg;

    assign last_ptr_k = 3'd3;
    assign unused_cfg = ^{FPU_PARAM_CFG,
                          TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14],
                          TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6], TA_ALLOC_CTRL[3:2]};
`endif

    // Base of list type k is the previous base plus the whole previous type's region.
    always_comb begin
        setup_base = ol_base_q;
        case (step_k)
            3'd1:    setup_base = base_q[0] + scaled(num_tiles, opb_q[0]);
            3'd2:    setup_base = base_q[1] + scaled(num_tiles, opb_q[1]);
            3'd3:    setup_base = base_q[2] + scaled(num_tiles, opb_q[2]);
            3'd4:    setup_base = base_q[3] + scaled(num_tiles, opb_q[3]);
            default: setup_base = ol_base_q;
        endcase
    end

    // Main sequencer: latch, compute bases, then walk tiles in raster order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            last_x    <= 6'd0;
            last_y    <= 6'd0;
            cur_x     <= 6'd0;
            cur_y     <= 6'd0;
            zclear_q  <= 1'b0;
            opb_q     <= '0;
            ol_base_q <= 24'd0;
            base_q    <= '0;
            step_k    <= 3'd0;
            tile_idx  <= 12'd0;
            addr_q    <= 24'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ra_build_trig) begin
                        last_x    <= tiles_x;
                        last_y    <= tiles_y;
                        zclear_q  <= zclear_dis;
                        opb_q[0]  <= TA_ALLOC_CTRL[1:0];
                        opb_q[1]  <= TA_ALLOC_CTRL[5:4];
                        opb_q[2]  <= TA_ALLOC_CTRL[9:8];
                        opb_q[3]  <= TA_ALLOC_CTRL[13:12];
                        opb_q[4]  <= TA_ALLOC_CTRL[17:16];
                        ol_base_q <= OL_BASE;
                        addr_q    <= REGION_BASE;
                        cur_x     <= 6'd0;
                        cur_y     <= 6'd0;
                        tile_idx  <= 12'd0;
                        step_k    <= 3'd0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    base_q[step_k] <= setup_base;
                    if (step_k == 3'd4) begin
                        step_k <= 3'd0;
                        state  <= S_WR_CTRL;
                    end else begin
                        step_k <= step_k + 3'd1;
                    end
                end
                S_WR_CTRL: begin
                    if (write_ok) begin
                        addr_q <= addr_q + 24'd4;
                        step_k <= 3'd0;
                        state  <= S_WR_PTR;
                    end
                end
                S_WR_PTR: begin
                    if (write_ok) begin
                        addr_q <= addr_q + 24'd4;
                        if (step_k == last_ptr_k) begin
                            state <= S_NEXT;
                        end else begin
                            step_k <= step_k + 3'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (is_last) begin
                        state <= S_DONE;
                    end else begin
                        tile_idx <= tile_idx + 12'd1;
                        if (cur_x == last_x) begin
                            cur_x <= 6'd0;
                            cur_y <= cur_y + 6'd1;
                        end else begin
                            cur_x <= cur_x + 6'd1;
                        end
                        state <= S_WR_CTRL;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write data follows the state; it only changes on an accepted write, so a stall holds it.
    always_comb begin
        ra_vram_dout = 32'd0;
        if (state == S_WR_CTRL) begin
            ra_vram_dout = ctrl_word;
        end else if (state == S_WR_PTR) begin
            ra_vram_dout = ptr_word;
        end
    end

    assign ra_vram_wr   = (state == S_WR_CTRL) || (state == S_WR_PTR);
    assign ra_vram_addr = addr_q;
    assign busy         = (state == S_SETUP) || (state == S_WR_CTRL) ||
                          (state == S_WR_PTR) || (state == S_NEXT);
    assign done         = (state == S_DONE);

endmodule

// File: tb/tb_ra_builder.sv
// tb_ra_builder
// Self-checking bench for ra_builder. A list-level model turns each build's
// configuration into the expected sequence of (address, data) writes; one
// monitor compares every accepted write, stall hold, busy and done timing.
// Honours RA_BUILDER_FMT_V2_EN the same way the design does.
`timescale 1ns/1ps
module tb_ra_builder;

    logic        clock;
    logic        reset;
    logic        ra_build_trig;
    logic [31:0] FPU_PARAM_CFG;
    logic [31:0] TA_ALLOC_CTRL;
    logic [23:0] REGION_BASE;
    logic [23:0] OL_BASE;
    logic [5:0]  tiles_x;
    logic [5:0]  tiles_y;
    logic        zclear_dis;
    logic        ra_vram_wr;
    logic [23:0] ra_vram_addr;
    logic [31:0] ra_vram_dout;
    logic        ra_vram_wait;
    logic        busy;
    logic        done;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          cycle = 0;
    logic [23:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          done_count = 0;
    int          writes_seen = 0;
    int          trig_cycle = 0;
    int          last_acc_cycle = 0;
    bit          build_active = 0;
    bit          first_wr_pending = 0;
    bit          prev_stall = 0;
    logic [23:0] prev_addr;
    logic [31:0] prev_data;
    int          stall_mode = 0;
    bit          directed_stall_done = 0;

    ra_builder dut (
        .clock         (clock),
        .reset         (reset),
        .ra_build_trig (ra_build_trig),
        .FPU_PARAM_CFG (FPU_PARAM_CFG),
        .TA_ALLOC_CTRL (TA_ALLOC_CTRL),
        .REGION_BASE   (REGION_BASE),
        .OL_BASE       (OL_BASE),
        .tiles_x       (tiles_x),
        .tiles_y       (tiles_y),
        .zclear_dis    (zclear_dis),
        .ra_vram_wr    (ra_vram_wr),
        .ra_vram_addr  (ra_vram_addr),
        .ra_vram_dout  (ra_vram_dout),
        .ra_vram_wait  (ra_vram_wait),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Expected write stream straight from the format rules.
    task automatic modelBuild(input logic [31:0] fpu, input logic [31:0] alloc,
                              input logic [23:0] rbase, input logic [23:0] olbase,
                              input int tx, input int ty, input logic zc);
        int          bytes [5];
        logic [23:0] base [5];
        logic [23:0] a;
        logic [23:0] p;
        logic [31:0] ctrl;
        int          ntiles;
        int          nptr;
        int          idx;
        int          opb;
        logic        use_v2;
        use_v2 = fpu[21];
`ifndef RA_BUILDER_FMT_V2_EN
        use_v2 = 1'b0;
`endif
        nptr   = use_v2 ? 5 : 4;
        ntiles = (tx + 1) * (ty + 1);
        for (int k = 0; k < 5; k++) begin
            opb      = int'((alloc >> (4 * k)) & 32'h3);
            bytes[k] = (opb == 0) ? 0 : (16 << opb);
        end
        base[0] = olbase;
        for (int k = 1; k < 5; k++) begin
            base[k] = base[k-1] + 24'(ntiles * bytes[k-1]);
        end
        a = rbase;
        for (int y = 0; y <= ty; y++) begin
            for (int x = 0; x <= tx; x++) begin
                idx        = y * (tx + 1) + x;
                ctrl       = 32'd0;
                ctrl[31]   = (x == tx) && (y == ty);
                ctrl[30]   = zc;
                ctrl[13:8] = 6'(y);
                ctrl[7:2]  = 6'(x);
                exp_addr.push_back(a);
                exp_data.push_back(ctrl);
                a = a + 24'd4;
                for (int k = 0; k < nptr; k++) begin
                    p = base[k] + 24'(idx * bytes[k]);
                    exp_addr.push_back(a);
                    exp_data.push_back((bytes[k] == 0) ? 32'h8000_0000 : {8'h00, p});
                    a = a + 24'd4;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fpu, input logic [31:0] alloc,
                                 input logic [23:0] rbase, input logic [23:0] olbase,
                                 input int tx, input int ty, input logic zc);
        FPU_PARAM_CFG = fpu;
        TA_ALLOC_CTRL = alloc;
        REGION_BASE   = rbase;
        OL_BASE       = olbase;
        tiles_x       = 6'(tx);
        tiles_y       = 6'(ty);
        zclear_dis    = zc;
        exp_addr.delete();
        exp_data.delete();
        modelBuild(fpu, alloc, rbase, olbase, tx, ty, zc);
    endtask

    task automatic randomConfig();
        int tx;
        int ty;
        if ($urandom_range(0, 7) == 0) begin
            tx = $urandom_range(0, 63);
            ty = $urandom_range(0, 1);
        end else begin
            tx = $urandom_range(0, 4);
            ty = $urandom_range(0, 3);
        end
        applyStimulus($urandom, $urandom, 24'($urandom) & 24'hFFFFFC, 24'($urandom),
                      tx, ty, 1'($urandom_range(0, 1)));
    endtask

    task automatic scrambleInputs();
        FPU_PARAM_CFG = $urandom;
        TA_ALLOC_CTRL = $urandom;
        REGION_BASE   = 24'($urandom);
        OL_BASE       = 24'($urandom);
        tiles_x       = 6'($urandom);
        tiles_y       = 6'($urandom);
        zclear_dis    = 1'($urandom);
    endtask

    task automatic triggerBuild();
        @(posedge clock);
        #1;
        writes_seen      = 0;
        trig_cycle       = cycle;
        build_active     = 1;
        first_wr_pending = 1;
        ra_build_trig    = 1'b1;
        @(posedge clock);
        #1;
        ra_build_trig = 1'b0;
    endtask

    task automatic waitDone(input int retrig_at, input int start_done);
        int n;
        n = 0;
        while (done_count == start_done && n < 20000) begin
            @(posedge clock);
            #1;
            n++;
            ra_build_trig = (n == retrig_at);
        end
        ra_build_trig = 1'b0;
        if (done_count == start_done) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL build_timeout: no done after %0d cycles, want a done pulse", n);
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            exp_addr.delete();
            exp_data.delete();
            build_active     = 0;
            first_wr_pending = 0;
        end else begin
            repeat (4) @(posedge clock);
            #1;
            checkOutput("done_pulses", done_count - start_done, 1);
        end
    endtask

    task automatic runBuild(input int retrig_at);
        int start_done;
        start_done = done_count;
        triggerBuild();
        scrambleInputs();
        waitDone(retrig_at, start_done);
    endtask

    // Stall driver: none, random, or a single 3-cycle stall on the third write.
    initial begin
        ra_vram_wait = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (stall_mode == 1) begin
                ra_vram_wait = ($urandom_range(0, 3) == 0);
            end else if (stall_mode == 2 && ra_vram_wr && writes_seen == 2 && !directed_stall_done) begin
                ra_vram_wait = 1'b1;
                repeat (3) @(posedge clock);
                #1;
                ra_vram_wait        = 1'b0;
                directed_stall_done = 1;
            end else begin
                ra_vram_wait = 1'b0;
            end
        end
    end

    // Monitor: compares each accepted write, stall hold, busy and done timing.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_hold_wr", 32'(ra_vram_wr), 32'd1);
                checkOutput("stall_hold_addr", 32'(ra_vram_addr), 32'(prev_addr));
                checkOutput("stall_hold_data", ra_vram_dout, prev_data);
            end
            if (ra_vram_wr && first_wr_pending) begin
                checkOutput("trig_to_first_write", cycle - trig_cycle, 32'd6);
                first_wr_pending = 0;
            end
            if (ra_vram_wr && !ra_vram_wait) begin
                if (exp_addr.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%06h data 0x%08h, want no write",
                             ra_vram_addr, ra_vram_dout);
                end else begin
                    checkOutput("write_addr", 32'(ra_vram_addr), 32'(exp_addr.pop_front()));
                    checkOutput("write_data", ra_vram_dout, exp_data.pop_front());
                end
                writes_seen++;
                last_acc_cycle = cycle;
            end
            if (done) begin
                done_count++;
                checkOutput("done_in_build", 32'(build_active), 32'd1);
                checkOutput("done_after_last_write", cycle - last_acc_cycle, 32'd2);
                checkOutput("writes_left_at_done", exp_addr.size(), 32'd0);
                build_active = 0;
            end else begin
                checkOutput("busy", 32'(busy), 32'(build_active && (cycle > trig_cycle)));
            end
            prev_stall = ra_vram_wr && ra_vram_wait;
            prev_addr  = ra_vram_addr;
            prev_data  = ra_vram_dout;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset         = 1'b1;
        ra_build_trig = 1'b0;
        FPU_PARAM_CFG = 32'd0;
        TA_ALLOC_CTRL = 32'd0;
        REGION_BASE   = 24'd0;
        OL_BASE       = 24'd0;
        tiles_x       = 6'd0;
        tiles_y       = 6'd0;
        zclear_dis    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_wr", 32'(ra_vram_wr), 32'd0);
        checkOutput("reset_addr", 32'(ra_vram_addr), 32'd0);
        checkOutput("reset_dout", ra_vram_dout, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        $display("[TB] two tiles, opaque only");
        applyStimulus(32'd0, 32'h1, 24'h2000, 24'h1000, 1, 0, 1'b0);
        checkOutput("pin1_count", exp_addr.size(), 32'd10);
        checkOutput("pin1_ctrl0", exp_data[0], 32'h0000_0000);
        checkOutput("pin1_o0", exp_data[1], 32'h0000_1000);
        checkOutput("pin1_om0", exp_data[2], 32'h8000_0000);
        checkOutput("pin1_ctrl1_addr", 32'(exp_addr[5]), 32'h2014);
        checkOutput("pin1_ctrl1", exp_data[5], 32'h8000_0004);
        checkOutput("pin1_o1", exp_data[6], 32'h0000_1020);
        runBuild(0);

        $display("[TB] two lists");
        applyStimulus(32'd0, 32'h201, 24'h2000, 24'h1000, 1, 0, 1'b0);
        checkOutput("pin2_t0", exp_data[3], 32'h0000_1040);
        checkOutput("pin2_t1", exp_data[8], 32'h0000_1080);
        checkOutput("pin2_om0", exp_data[2], 32'h8000_0000);
        checkOutput("pin2_tm0", exp_data[4], 32'h8000_0000);
        runBuild(0);

        $display("[TB] PT format select");
        applyStimulus(32'h0020_0000, 32'h0003_0000, 24'h4000, 24'h0, 1, 1, 1'b0);
`ifdef RA_BUILDER_FMT_V2_EN
        checkOutput("pin3_count", exp_addr.size(), 32'd24);
        checkOutput("pin3_pt0", exp_data[5], 32'h0000_0000);
        checkOutput("pin3_pt1", exp_data[11], 32'h0000_0080);
        checkOutput("pin3_pt2", exp_data[17], 32'h0000_0100);
        checkOutput("pin3_pt3", exp_data[23], 32'h0000_0180);
        checkOutput("pin3_last_ctrl", exp_data[18], 32'h8000_0104);
`else
        checkOutput("pin3_count", exp_addr.size(), 32'd20);
        checkOutput("pin3_last_ctrl", exp_data[15], 32'h8000_0104);
`endif
        runBuild(0);

        $display("[TB] single tile");
        applyStimulus(32'd0, 32'h0001_2121, 24'h0100, 24'h0500, 0, 0, 1'b1);
        checkOutput("pin4_ctrl", exp_data[0], 32'hC000_0000);
        runBuild(0);

        $display("[TB] directed stall on third write");
        directed_stall_done = 0;
        stall_mode = 2;
        applyStimulus(32'd0, 32'h0000_1111, 24'h6000, 24'h7000, 1, 1, 1'b0);
        runBuild(0);
        stall_mode = 0;
        checkOutput("directed_stall_seen", 32'(directed_stall_done), 32'd1);

        $display("[TB] trig while busy");
        applyStimulus(32'd0, 32'h0000_0102, 24'h8000, 24'h9000, 2, 1, 1'b0);
        runBuild(8);

        $display("[TB] trig on done cycle");
        applyStimulus(32'd0, 32'h1, 24'h2000, 24'h1000, 1, 0, 1'b0);
        runBuild(5 + 2 * 6);

        $display("[TB] reset mid-build");
        applyStimulus(32'd0, 32'h0001_1111, 24'h3000, 24'h8000, 2, 2, 1'b0);
        triggerBuild();
        n = 0;
        while (writes_seen < 6 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("abort_point_reached", 32'(writes_seen >= 6), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_wr", 32'(ra_vram_wr), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_addr", 32'(ra_vram_addr), 32'd0);
        checkOutput("abort_dout", ra_vram_dout, 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        build_active     = 0;
        first_wr_pending = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(32'd0, 32'h0001_1111, 24'h3000, 24'h8000, 2, 2, 1'b0);
        runBuild(0);

        $display("[TB] randomized builds");
        for (int i = 0; i < 30; i++) begin
            stall_mode = $urandom_range(0, 1);
            randomConfig();
            runBuild(($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0);
        end
        stall_mode = 0;

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ra_builder.md
# ra_builder

Writes a complete PVR Region Array into VRAM for an N×M tile grid, one entry per tile. It is the producer side of the format that the region-array parser walks. Each entry holds a control word plus one Object List pointer per list type. Pointers are laid out from a common OL base using the per-type OPB sizes in `TA_ALLOC_CTRL`, so the builder and the parser agree on the list geometry. The block sits between the TA register file and the VRAM write arbiter, and runs once per frame before the renderer is triggered.

## Interface
Parameters:
- none (all geometry comes from registers/ports).

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `ra_build_trig` in 1: one-cycle start pulse; ignored while `busy`.
- `FPU_PARAM_CFG` in 32: bit 21 selects entry format (0=v1 five words, 1=v2 six words).
- `TA_ALLOC_CTRL` in 32: OPB sizes; `o`=[1:0], `om`=[5:4], `t`=[9:8], `tm`=[13:12], `pt`=[17:16].
- `REGION_BASE` in 24: byte address of the first RA entry.
- `OL_BASE` in 24: OL offset (relative to PARAM_BASE) where the opaque lists start.
- `tiles_x` in 6: last tile X index (width−1).
- `tiles_y` in 6: last tile Y index (height−1).
- `zclear_dis` in 1: copied into control bit 30 of every entry.
- `ra_vram_wr` out 1: write request.
- `ra_vram_addr` out 24: byte address.
- `ra_vram_dout` out 32: write data.
- `ra_vram_wait` in 1: stall. A write is accepted when `ra_vram_wr` is high and `ra_vram_wait` is low.
- `busy` out 1: high from the cycle after trig until `done`.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- **OPB size per type:** `bytes = 0` if opb==0, else `16<<opb`. This gives 32, 64 or 128 bytes.
- **num_tiles** = `(tiles_x+1)*(tiles_y+1)`, range 1..4096.
- **List bases:** `base[0] = OL_BASE` and `base[k+1] = base[k] + num_tiles*bytes[k]`, in type order O, OM, T, TM, PT. All arithmetic is 24-bit modulo.
- **Tile order:** raster, Y outer and X inner. `tile_index = y*(tiles_x+1) + x`.
- **Control word:**
  - bit31 is set only on the last tile (x=tiles_x, y=tiles_y).
  - bit30 = `zclear_dis`; bit28 = 0.
  - [13:8] = y; [7:2] = x; all other bits are 0.
- **Pointer word for type k:** `0x80000000` if `bytes[k]==0`, else `{8'h00, base[k] + tile_index*bytes[k]}`.
- **Entry layout:** ctrl, O, OM, T, TM, then PT only in v2. Addresses are consecutive from `REGION_BASE`, in steps of +4.
- **States:**
  - IDLE: on trig, latch all inputs, clear x/y, go to SETUP.
  - SETUP: 5 cycles, one base per cycle (k=0..4).
  - WR_CTRL.
  - WR_PTR: k=0..3, or 0..4 in v2.
  - NEXT: advance x/y. If the last tile is done, go to DONE; otherwise go to WR_CTRL.
  - DONE: pulse `done`, return to IDLE.
- **Input sampling:** inputs are sampled only at trig; later register changes do not affect the current build.
- **Stall:** while `ra_vram_wait` is high, `ra_vram_wr`, `ra_vram_addr` and `ra_vram_dout` are held stable and the state does not advance.

## Timing
- **Reset values:** `ra_vram_wr`=0, `ra_vram_addr`=0, `ra_vram_dout`=0, `busy`=0, `done`=0; state=IDLE.
- **Write strobe:** `ra_vram_wr` is asserted in WR_CTRL and WR_PTR states only. It is never asserted in SETUP, NEXT or DONE.
- **Latency with no stalls:**
  - trig to first write is 6 cycles (1 latch + 5 SETUP).
  - Each entry takes 5 (v1) or 6 (v2) write cycles plus 1 NEXT cycle.
  - `done` is asserted on the cycle after NEXT of the last tile.
- **Trig while busy:** ignored, with no effect on the build in progress.
- **Trig coincident with the `done` cycle:** ignored. A new build needs trig in IDLE.
- **Reset mid-build:** immediate return to IDLE, with all outputs at their reset values. No partial-entry completion.
- **Single-tile grid** (tiles_x=tiles_y=0): exactly one entry, and its control word has bit31 set.

## Configuration
- **`RA_BUILDER_FMT_V2_EN` defined:** `FPU_PARAM_CFG[21]` selects v1 or v2. In v2 each entry gets a sixth PT pointer word.
- **`RA_BUILDER_FMT_V2_EN` undefined:**
  - v1 is always used and `FPU_PARAM_CFG[21]` is ignored.
  - `pt` is still counted in the base chain but is never written.
  - The PT-state logic is not synthesised.

## Test plan
- **Two tiles, opaque only, v1:** tiles_x=1, tiles_y=0, `TA_ALLOC_CTRL`=0x1, `OL_BASE`=0x1000, `REGION_BASE`=0x2000 →
  - 0x2000←0x00000000, 0x2004←0x00001000, 0x2008/0x200C/0x2010←0x80000000;
  - 0x2014←0x80000004, 0x2018←0x00001020;
  - then one `done` pulse.
- **Two lists:** same setup but `TA_ALLOC_CTRL`=0x201 → T pointers are 0x00001040 (tile 0) and 0x00001080 (tile 1); OM and TM are 0x80000000.
- **v2 with macro defined:** `FPU_PARAM_CFG[21]`=1, pt=3, others 0, 2×2 grid, `OL_BASE`=0 →
  - six words per entry;
  - PT pointers are 0x0, 0x80, 0x100, 0x180;
  - the last control word is 0x80000104;
  - 24 writes in total.
- **Stall:** hold `ra_vram_wait`=1 for 3 cycles during the 3rd write → address and data stay frozen; total write count is unchanged; there are no duplicate addresses.
- **Trig while busy:** a second trig mid-build → ignored; exactly one `done`.
- **Reset mid-build:** assert `reset` during entry 1 → `busy`=0 and `ra_vram_wr`=0 at once. A new trig restarts from `REGION_BASE`.
